rv32_ifetch: RTL
================

RV32_IFETCH -- requirements
Module: rv32_ifetch

Interface
REQ-001 Parameter XPR_LEN, default 32, datapath width; the block SHALL support only 32.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be treated as 0.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  instruction memory accepts the request this cycle.
REQ-007 imem_req_addr  output  XPR_LEN  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  instruction word returned; one response per accepted request, in order, 1 or more cycles after acceptance.
REQ-009 imem_rsp_data  input  XPR_LEN  returned instruction word.
REQ-010 redirect_valid  input  1  single-cycle pulse; flush and restart fetch at redirect_pc.
REQ-011 redirect_pc  input  XPR_LEN  new fetch address; bits [1:0] SHALL be ignored.
REQ-012 instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
REQ-013 instr_ready  input  1  the decode stage (immediate generator consumer) accepts instr.
REQ-014 instr  output  XPR_LEN  fetched instruction word, fed to the decode stage and the immediate generator.
REQ-015 instr_pc  output  XPR_LEN  address of instr.

Function
REQ-016 The block SHALL hold a fetch PC register, at most one outstanding memory request, a stale flag, and a 2-entry in-order output FIFO of {instr, pc}.
REQ-017 FSM states: REQ (imem_req_valid=1), WAIT (one request outstanding), STALL (no request and none outstanding, FIFO space exhausted).
REQ-018 REQ: on imem_req_valid && imem_req_ready -> WAIT, PC <= PC+4, recording the accepted address for the response.
REQ-019 WAIT: on imem_rsp_valid the block SHALL write {imem_rsp_data, recorded address} into the FIFO unless stale, then -> REQ if FIFO occupancy after this cycle is below 2, else -> STALL.
REQ-020 STALL: -> REQ in the cycle after an instr handshake leaves occupancy below 2.
REQ-021 REQ SHALL be entered only while occupancy plus outstanding count is at most 1, so the FIFO never overflows; a response that finds the FIFO full SHALL NOT occur.
REQ-022 imem_req_addr SHALL equal PC; in REQ it SHALL stay stable until accepted, except on redirect.
REQ-023 Latency: a response in cycle N SHALL appear on instr with instr_valid=1 in cycle N+1 when the FIFO was empty (no combinational bypass).
REQ-024 instr_valid SHALL be 1 iff the FIFO is non-empty; instr and instr_pc SHALL show the FIFO head and stay stable while instr_valid && !instr_ready.
REQ-025 Simultaneous FIFO write and read SHALL keep occupancy unchanged and preserve order.
REQ-026 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
REQ-027 Redirect SHALL take priority over all other events in its cycle:
  - PC <= {redirect_pc[31:2], 2'b00};
  - the FIFO is emptied (instr_valid=0 next cycle), but an instr handshake in the redirect cycle still counts as consumed;
  - a response arriving in the redirect cycle SHALL be dropped;
  - a request outstanding after the redirect cycle, including one accepted in that cycle, SHALL set stale, and its later response SHALL be dropped;
  - next state: WAIT if a request is outstanding after the cycle, else REQ.
REQ-028 Stale SHALL clear when the dropped response arrives; in that cycle the FSM SHALL go -> REQ, because the FIFO is empty.
REQ-029 From REQ, a redirect SHALL change imem_req_addr in the next cycle while imem_req_valid stays 1.

Reset
REQ-030 While rst_n=0, the block SHALL drive imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, imem_req_addr=RESET_PC, and hold PC=RESET_PC, state=REQ, FIFO empty, no outstanding request, stale=0.
REQ-031 In the first clk edge after rst_n deasserts, imem_req_valid SHALL be 1 with imem_req_addr=RESET_PC.
REQ-032 Reset asserted mid-transaction SHALL discard all in-flight state; responses to pre-reset requests are outside the protocol.

Verification
REQ-033 Reset release, memory always ready, 1-cycle response with data 32'h00000013 -> instr_pc sequence 0x0,0x4,0x8, each instr=32'h00000013, instr_valid the cycle after each response.
REQ-034 instr_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid=0 in STALL, instr/instr_pc stable; on instr_ready=1, entries drain in order and fetch resumes at the next PC.
REQ-035 Redirect to 32'h0000_0102 while a request is outstanding -> next request addr 32'h0000_0100; the old response is dropped; first delivered instr_pc=0x100.
REQ-036 Redirect in the same cycle as imem_rsp_valid and an instr handshake -> the handshaken entry is consumed, the response is dropped, and instr_valid=0 next cycle.
REQ-037 RESET_PC=32'hFFFF_FFF8, memory always ready -> instr_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-038 rst_n pulsed low asynchronously mid-WAIT with 2 FIFO entries -> outputs go to the reset values immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32_ifetch.sv
// rv32_ifetch -- RV32 instruction fetch unit.
// Fetches instructions with at most one request outstanding to instruction
// memory and buffers returned words in a 2-entry in-order FIFO of
// {instr, pc}. A redirect flushes the FIFO and restarts fetch. A request
// still in flight across a redirect is marked stale, and its response is
// dropped when it arrives.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   imem_req_valid/ready/addr     fetch request channel (addr = PC)
//   imem_rsp_valid/data           in-order fetch response channel
//   redirect_valid/pc             single-cycle flush and restart
//   instr_valid/ready, instr,     fetched instruction to decode
//   instr_pc
// Only XPR_LEN = 32 is supported.
module rv32_ifetch #(
  parameter int unsigned           XPR_LEN  = 32,
  parameter logic [XPR_LEN-1:0]    RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XPR_LEN-1:0] imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [XPR_LEN-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XPR_LEN-1:0] redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [XPR_LEN-1:0] instr,
  output logic [XPR_LEN-1:0] instr_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_STALL} state_t;

  localparam logic [XPR_LEN-1:0] ALIGN_MASK = {{(XPR_LEN-2){1'b1}}, 2'b00};
  localparam logic [XPR_LEN-1:0] PC_RST     = RESET_PC & ALIGN_MASK;
  localparam logic [XPR_LEN-1:0] PC_STEP    = XPR_LEN'(4);

  state_t                   state_q, state_d;
  logic                     req_valid_q, req_valid_d;
  logic [XPR_LEN-1:0]       pc_q, pc_d;
  logic [XPR_LEN-1:0]       rsp_addr_q, rsp_addr_d;
  logic                     stale_q, stale_d;
  logic [1:0][XPR_LEN-1:0]  fifo_instr_q, fifo_instr_d;
  logic [1:0][XPR_LEN-1:0]  fifo_pc_q, fifo_pc_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic [1:0]               count_q, count_d;

  logic                     req_fire;
  logic                     rsp_fire;
  logic                     deq;
  logic                     push;
  logic                     outstanding_after;
  logic [1:0]               occ_with_push;

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    rsp_addr_d        = rsp_addr_q;
    stale_d           = stale_q;
    fifo_instr_d      = fifo_instr_q;
    fifo_pc_d         = fifo_pc_q;
    rd_ptr_d          = rd_ptr_q;
    wr_ptr_d          = wr_ptr_q;
    count_d           = count_q;
    push              = 1'b0;
    outstanding_after = 1'b0;

    req_fire      = req_valid_q & imem_req_ready;
    rsp_fire      = imem_rsp_valid & (state_q == S_WAIT);
    deq           = (count_q != 2'd0) & instr_ready;
    occ_with_push = count_q + 2'd1 - {1'b0, deq};

    if (redirect_valid) begin
      // Redirect wins: flush everything, but a request accepted now (or
      // still in flight) keeps us in WAIT so its response can be dropped.
      outstanding_after = req_fire | ((state_q == S_WAIT) & ~imem_rsp_valid);
      if (req_fire) rsp_addr_d = pc_q;
      pc_d     = redirect_pc & ALIGN_MASK;
      stale_d  = outstanding_after;
      state_d  = outstanding_after ? S_WAIT : S_REQ;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d    = S_WAIT;
            rsp_addr_d = pc_q;
            pc_d       = pc_q + PC_STEP;
          end
        end
        S_WAIT: begin
          if (rsp_fire) begin
            if (stale_q) begin
              // A stale response only exists after a flush, so the FIFO is empty.
              stale_d = 1'b0;
              state_d = S_REQ;
            end else begin
              push    = 1'b1;
              state_d = (occ_with_push < 2'd2) ? S_REQ : S_STALL;
            end
          end
        end
        S_STALL: begin
          if (deq) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase

      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem_rsp_data;
        fifo_pc_d[wr_ptr_q]    = rsp_addr_q;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (deq) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, deq};
    end

    req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      req_valid_q  <= 1'b0;
      pc_q         <= PC_RST;
      rsp_addr_q   <= '0;
      stale_q      <= 1'b0;
      fifo_instr_q <= '0;
      fifo_pc_q    <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      pc_q         <= pc_d;
      rsp_addr_q   <= rsp_addr_d;
      stale_q      <= stale_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (count_q != 2'd0);
  assign instr          = fifo_instr_q[rd_ptr_q];
  assign instr_pc       = fifo_pc_q[rd_ptr_q];

endmodule
